// File: rtl/sram_march_bist.sv
// -----------------------------------------------------------------------------
// sram_march_bist
//
// March-style built-in self test for a single-port synchronous SRAM.
//
// A run consists of four passes over the whole array:
//   1. write P(a) ascending
//   2. read and compare P(a) ascending, then drain the read pipeline
//   3. write ~P(a) descending
//   4. read and compare ~P(a) descending, then drain the read pipeline
//
// P(a) is picked by BIST_mode, which is latched when a run starts:
//   0 = address value, 1 = checkerboard, 2 = all zeros, 3 = inverted address.
//
// Ports
//   Clock              in   single rising-edge clock
//   Resetn             in   asynchronous active-low reset
//   BIST_start         in   rising edge requests a run (only honoured when idle)
//   BIST_mode          in   pattern select, latched at run start
//   BIST_address       out  SRAM address
//   BIST_write_data    out  SRAM write data (zero outside write passes)
//   BIST_we_n          out  SRAM write enable, active-low
//   BIST_read_data     in   SRAM read data, valid RD_LAT cycles after address
//   BIST_finish        out  run complete, held until the next run starts
//   BIST_mismatch      out  sticky, at least one read compare failed
//   BIST_fail_address  out  address of the first failing read
//   BIST_error_count   out  saturating count of failing reads
//
// State table
//   state       | meaning
//   S_IDLE      | waiting for start; outputs parked, results held
//   S_WR_UP     | write P(a), a = 0 .. DEPTH-1
//   S_RD_UP     | issue reads expecting P(a), a = 0 .. DEPTH-1
//   S_DRAIN_UP  | RD_LAT cycles letting in-flight reads reach the compare
//   S_WR_DN     | write ~P(a), a = DEPTH-1 .. 0
//   S_RD_DN     | issue reads expecting ~P(a), a = DEPTH-1 .. 0
//   S_DRAIN_DN  | RD_LAT cycles of drain, then finish
// -----------------------------------------------------------------------------
module sram_march_bist #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              BIST_start,
    input  logic [1:0]        BIST_mode,
    output logic [ADDR_W-1:0] BIST_address,
    output logic [DATA_W-1:0] BIST_write_data,
    output logic              BIST_we_n,
    input  logic [DATA_W-1:0] BIST_read_data,
    output logic              BIST_finish,
    output logic              BIST_mismatch,
    output logic [ADDR_W-1:0] BIST_fail_address,
    output logic [CNT_W-1:0]  BIST_error_count
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam int                DRN_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DRN_W-1:0]  DRN_LOAD  = DRN_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_UP,
        S_RD_UP,
        S_DRAIN_UP,
        S_WR_DN,
        S_RD_DN,
        S_DRAIN_DN
    } state_t;

    state_t                          state_q, state_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic [DRN_W-1:0]                drain_q, drain_d;
    logic [1:0]                      mode_q, mode_d;
    logic                            finish_q, finish_d;
    logic                            mism_q, mism_d;
    logic [ADDR_W-1:0]               fail_q, fail_d;
    logic [CNT_W-1:0]                err_q, err_d;

    logic                            start_q;
    logic                            arm_q;
    logic                            start_det_q;

    logic [RD_LAT-1:0]               pv_q;
    logic [RD_LAT-1:0][DATA_W-1:0]   pexp_q;
    logic [RD_LAT-1:0][ADDR_W-1:0]   paddr_q;

    logic                            rd_push;
    logic [DATA_W-1:0]               rd_exp;
    logic                            run_clear;
    logic                            cmp_fail;

    function automatic logic [DATA_W-1:0] pat_f(input logic [ADDR_W-1:0] a,
                                                input logic [1:0]        m);
        logic [DATA_W-1:0] lin;
        lin = DATA_W'(a);
        case (m)
            2'd0:    pat_f = lin;
            2'd1:    pat_f = a[0] ? {(DATA_W/2){2'b01}} : {(DATA_W/2){2'b10}};
            2'd2:    pat_f = '0;
            default: pat_f = ~lin;
        endcase
    endfunction

    // Start detection. arm_q is only set once BIST_start has been seen low
    // after reset, so a start level held high through reset release is not
    // mistaken for a fresh rising edge.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            start_q     <= 1'b0;
            arm_q       <= 1'b0;
            start_det_q <= 1'b0;
        end else begin
            start_q     <= BIST_start;
            arm_q       <= arm_q | ~BIST_start;
            start_det_q <= BIST_start & ~start_q & arm_q & (state_q == S_IDLE);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            drain_q  <= '0;
            mode_q   <= '0;
            finish_q <= 1'b0;
            mism_q   <= 1'b0;
            fail_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            drain_q  <= drain_d;
            mode_q   <= mode_d;
            finish_q <= finish_d;
            mism_q   <= mism_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        drain_d         = drain_q;
        mode_d          = mode_q;
        finish_d        = finish_q;
        run_clear       = 1'b0;
        rd_push         = 1'b0;
        rd_exp          = '0;
        BIST_we_n       = 1'b1;
        BIST_write_data = '0;

        case (state_q)
            S_IDLE: begin
                if (start_det_q) begin
                    state_d   = S_WR_UP;
                    addr_d    = '0;
                    mode_d    = BIST_mode;
                    finish_d  = 1'b0;
                    run_clear = 1'b1;
                end
            end
            S_WR_UP: begin
                BIST_we_n       = 1'b0;
                BIST_write_data = pat_f(addr_q, mode_q);
                if (addr_q == ADDR_LAST) begin
                    state_d = S_RD_UP;
                    addr_d  = '0;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            S_RD_UP: begin
                rd_push = 1'b1;
                rd_exp  = pat_f(addr_q, mode_q);
                if (addr_q == ADDR_LAST) begin
                    state_d = S_DRAIN_UP;
                    drain_d = DRN_LOAD;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN_UP: begin
                if (drain_q == '0) begin
                    state_d = S_WR_DN;
                    addr_d  = ADDR_LAST;
                end else begin
                    drain_d = drain_q - DRN_W'(1);
                end
            end
            S_WR_DN: begin
                BIST_we_n       = 1'b0;
                BIST_write_data = ~pat_f(addr_q, mode_q);
                if (addr_q == '0) begin
                    state_d = S_RD_DN;
                    addr_d  = ADDR_LAST;
                end else begin
                    addr_d  = addr_q - ADDR_W'(1);
                end
            end
            S_RD_DN: begin
                rd_push = 1'b1;
                rd_exp  = ~pat_f(addr_q, mode_q);
                if (addr_q == '0) begin
                    state_d = S_DRAIN_DN;
                    drain_d = DRN_LOAD;
                end else begin
                    addr_d  = addr_q - ADDR_W'(1);
                end
            end
            S_DRAIN_DN: begin
                if (drain_q == '0) begin
                    state_d  = S_IDLE;
                    addr_d   = '0;
                    finish_d = 1'b1;
                end else begin
                    drain_d  = drain_q - DRN_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    // Read compare pipeline: expected data and address ride alongside the
    // SRAM read latency so the compare lines up with BIST_read_data.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pv_q    <= '0;
            pexp_q  <= '0;
            paddr_q <= '0;
        end else begin
            pv_q[0]    <= rd_push;
            pexp_q[0]  <= rd_exp;
            paddr_q[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i]    <= pv_q[i-1];
                pexp_q[i]  <= pexp_q[i-1];
                paddr_q[i] <= paddr_q[i-1];
            end
        end
    end

    assign cmp_fail = pv_q[RD_LAT-1] && (BIST_read_data != pexp_q[RD_LAT-1]);

    always_comb begin
        mism_d = mism_q;
        fail_d = fail_q;
        err_d  = err_q;
        if (run_clear) begin
            mism_d = 1'b0;
            fail_d = '0;
            err_d  = '0;
        end else if (cmp_fail) begin
            mism_d = 1'b1;
            // Only the first failure of a run is recorded.
            if (!mism_q) begin
                fail_d = paddr_q[RD_LAT-1];
            end
            if (err_q != {CNT_W{1'b1}}) begin
                err_d = err_q + CNT_W'(1);
            end
        end
    end

    assign BIST_address      = addr_q;
    assign BIST_finish       = finish_q;
    assign BIST_mismatch     = mism_q;
    assign BIST_fail_address = fail_q;
    assign BIST_error_count  = err_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// -----------------------------------------------------------------------------
// tb_sram_march_bist
//
// Drives sram_march_bist (ADDR_W=4, DATA_W=16, RD_LAT=2) against a behavioural
// SRAM with selectable faults. Expected writes and run results are queued when
// a run is launched and popped as the DUT produces them. A second instance with
// a 2-bit error counter reads a constant word to exercise saturation.
// -----------------------------------------------------------------------------
module tb_sram_march_bist;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int RL    = 2;
    localparam int DEPTH = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode  = 2'd0;

    logic [AW-1:0] addr, fail_addr;
    logic [DW-1:0] wdata, rdata;
    logic          we_n, finish, mism;
    logic [15:0]   err_cnt;

    logic [AW-1:0] addr_s, fail_s;
    logic [DW-1:0] wdata_s;
    logic          we_n_s, finish_s, mism_s;
    logic [1:0]    err_s;
    logic [DW-1:0] rdata_s;

    int            n_vec   = 0;
    int            n_miss  = 0;
    int            fault   = 0;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ra1, ra2;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        int            cyc;
        logic          mis;
        logic [AW-1:0] fa;
        logic [15:0]   cnt;
    } res_t;

    wr_t  wq[$];
    res_t rq[$];

    always #5 clk = ~clk;

    sram_march_bist #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .CNT_W(16)) dut (
        .Clock             (clk),
        .Resetn            (rst_n),
        .BIST_start        (start),
        .BIST_mode         (mode),
        .BIST_address      (addr),
        .BIST_write_data   (wdata),
        .BIST_we_n         (we_n),
        .BIST_read_data    (rdata),
        .BIST_finish       (finish),
        .BIST_mismatch     (mism),
        .BIST_fail_address (fail_addr),
        .BIST_error_count  (err_cnt)
    );

    assign rdata_s = 16'h1234;

    sram_march_bist #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .CNT_W(2)) dut_sat (
        .Clock             (clk),
        .Resetn            (rst_n),
        .BIST_start        (start),
        .BIST_mode         (mode),
        .BIST_address      (addr_s),
        .BIST_write_data   (wdata_s),
        .BIST_we_n         (we_n_s),
        .BIST_read_data    (rdata_s),
        .BIST_finish       (finish_s),
        .BIST_mismatch     (mism_s),
        .BIST_fail_address (fail_s),
        .BIST_error_count  (err_s)
    );

    // SRAM model: synchronous write, two-stage registered read address.
    // fault 1: bit 3 stuck at 1 at address 5; fault 2: address 9 ignores
    // writes and reads all ones.
    always @(posedge clk) begin
        if (!we_n && !(fault == 2 && addr == 4'd9)) mem[addr] <= wdata;
        ra1 <= addr;
        ra2 <= ra1;
    end

    always_comb begin
        rdata = mem[ra2];
        if (fault == 1 && ra2 == 4'd5) rdata = mem[ra2] | 16'h0008;
        if (fault == 2 && ra2 == 4'd9) rdata = 16'hFFFF;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_pat(input int a, input int m);
        case (m)
            0:       return 16'(a);
            1:       return (a % 2 == 1) ? 16'h5555 : 16'hAAAA;
            2:       return 16'h0000;
            default: return 16'hFFFF ^ 16'(a);
        endcase
    endfunction

    task automatic push_writes(input int m);
        wr_t e;
        for (int a = 0; a < DEPTH; a++) begin
            e.a = 4'(a);
            e.d = ref_pat(a, m);
            wq.push_back(e);
        end
        for (int a = DEPTH - 1; a >= 0; a--) begin
            e.a = 4'(a);
            e.d = ~ref_pat(a, m);
            wq.push_back(e);
        end
    endtask

    initial begin : wr_mon
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !we_n) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected", 64'd1, 64'd0);
                end else begin
                    e = wq.pop_front();
                    chk("wr_addr", 64'(addr), 64'(e.a));
                    chk("wr_data", 64'(wdata), 64'(e.d));
                end
            end
        end
    end

    // Launches one run; inj pulses a second start while the down-write pass
    // is in progress.
    task automatic run_test(input int m, input int f, input bit inj,
                            input logic exp_mis, input logic [AW-1:0] exp_fa,
                            input logic [15:0] exp_cnt);
        res_t r;
        res_t got;
        int   cyc;
        fault = f;
        mode  = 2'(m);
        push_writes(m);
        r.cyc = 4 * DEPTH + 2 * RL + 1;
        r.mis = exp_mis;
        r.fa  = exp_fa;
        r.cnt = exp_cnt;
        rq.push_back(r);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (inj) start = (cyc == 40);
        end while (!finish && cyc < 300);
        start = 1'b0;
        got = rq.pop_front();
        chk("run_cycles", 64'(cyc), 64'(got.cyc));
        chk("mismatch", 64'(mism), 64'(got.mis));
        chk("fail_addr", 64'(fail_addr), 64'(got.fa));
        chk("err_count", 64'(err_cnt), 64'(got.cnt));
        chk("writes_left", 64'(wq.size()), 64'd0);
        chk("idle_we_n", 64'(we_n), 64'd1);
        chk("idle_addr", 64'(addr), 64'd0);
        chk("idle_wdata", 64'(wdata), 64'd0);
        repeat (3) @(posedge clk);
        #1 chk("finish_held", 64'(finish), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        #12;
        chk("rst_we_n", 64'(we_n), 64'd1);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_finish", 64'(finish), 64'd0);
        chk("rst_mismatch", 64'(mism), 64'd0);
        chk("rst_fail_addr", 64'(fail_addr), 64'd0);
        chk("rst_err_count", 64'(err_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_test(0, 0, 1'b0, 1'b0, 4'd0, 16'd0);
        chk("sat_finish", 64'(finish_s), 64'd1);
        chk("sat_mismatch", 64'(mism_s), 64'd1);
        chk("sat_fail_addr", 64'(fail_s), 64'd0);
        chk("sat_err_count", 64'(err_s), 64'd3);

        run_test(1, 1, 1'b0, 1'b1, 4'd5, 16'd1);
        run_test(2, 2, 1'b0, 1'b1, 4'd9, 16'd1);
        run_test(3, 0, 1'b0, 1'b0, 4'd0, 16'd0);
        run_test(0, 0, 1'b1, 1'b0, 4'd0, 16'd0);

        // Abort a faulty run in the up-read pass with start held high.
        fault = 1;
        mode  = 2'd1;
        push_writes(1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("pre_rst_mismatch", 64'(mism), 64'd1);
        chk("pre_rst_fail_addr", 64'(fail_addr), 64'd5);
        chk("pre_rst_we_n", 64'(we_n), 64'd1);
        start = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("abort_we_n", 64'(we_n), 64'd1);
        chk("abort_addr", 64'(addr), 64'd0);
        chk("abort_finish", 64'(finish), 64'd0);
        chk("abort_mismatch", 64'(mism), 64'd0);
        chk("abort_fail_addr", 64'(fail_addr), 64'd0);
        chk("abort_err_count", 64'(err_cnt), 64'd0);
        chk("abort_wdata", 64'(wdata), 64'd0);
        wq.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("no_restart_we_n", 64'(we_n), 64'd1);
            chk("no_restart_addr", 64'(addr), 64'd0);
        end
        start = 1'b0;
        fault = 0;
        repeat (2) @(negedge clk);
        run_test(0, 0, 1'b0, 1'b0, 4'd0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
